// File: rtl/register_tree_pq.sv
// register_tree_pq: register-based binary max-heap priority queue with
// one compare per cycle sift-up/sift-down sequencing.
module register_tree_pq #(
    parameter int DATA_WIDTH = 32,
    parameter int TREE_DEPTH = 3,
    localparam int N = (1 << TREE_DEPTH) - 1,
    localparam int CW = $clog2(N + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_enq,
    input  logic [DATA_WIDTH-1:0] i_enq_data,
    input  logic                  i_deq,
    output logic [DATA_WIDTH-1:0] o_top,
    output logic                  o_top_valid,
    output logic                  o_busy,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [CW-1:0]         o_count
);
    typedef enum logic [1:0] {IDLE, SIFT_UP, SIFT_DOWN} state_t;
    localparam logic [CW-1:0] NMAX = CW'(N);
    state_t state_q, state_d;
    logic [DATA_WIDTH-1:0] node_q [N];
    logic [DATA_WIDTH-1:0] node_d [N];
    logic [CW-1:0] cnt_q, cnt_d, cur_q, cur_d, par, li, ri, pick, last;
    logic [CW:0] lc, rc;
    logic lv, rv, full;
    always_comb begin
        lc = {cur_q, 1'b1};
        rc = lc + 1'b1;
        lv = lc < {1'b0, cnt_q};
        rv = rc < {1'b0, cnt_q};
        // Clamp out-of-range child indices so reads stay inside the array
        li = lv ? lc[CW-1:0] : '0;
        ri = rv ? rc[CW-1:0] : '0;
        pick = (rv && node_q[ri] > node_q[li]) ? ri : li;
        par = (cur_q == '0) ? '0 : (cur_q - 1'b1) >> 1;
        last = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        full = cnt_q == NMAX;
        node_d = node_q;
        cnt_d = cnt_q;
        cur_d = cur_q;
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_enq && i_deq && cnt_q != '0) begin
                    node_d[0] = i_enq_data;
                    cur_d = '0;
                    state_d = SIFT_DOWN;
                end else if (i_enq && !full) begin
                    node_d[cnt_q] = i_enq_data;
                    cur_d = cnt_q;
                    cnt_d = cnt_q + 1'b1;
                    state_d = SIFT_UP;
                end else if (i_deq && !i_enq && cnt_q > 1) begin
                    node_d[0] = node_q[last];
                    node_d[last] = '0;
                    cnt_d = last;
                    cur_d = '0;
                    state_d = SIFT_DOWN;
                end else if (i_deq && !i_enq && cnt_q == 1) begin
                    node_d[0] = '0;
                    cnt_d = '0;
                end
            end
            SIFT_UP: begin
                if (cur_q == '0 || node_q[cur_q] <= node_q[par]) begin
                    state_d = IDLE;
                end else begin
                    node_d[cur_q] = node_q[par];
                    node_d[par] = node_q[cur_q];
                    cur_d = par;
                end
            end
            SIFT_DOWN: begin
                // Strict compare: equal keys stop the walk
                if (!lv || !(node_q[pick] > node_q[cur_q])) begin
                    state_d = IDLE;
                end else begin
                    node_d[cur_q] = node_q[pick];
                    node_d[pick] = node_q[cur_q];
                    cur_d = pick;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) node_q[k] <= '0;
            cnt_q <= '0;
            cur_q <= '0;
            state_q <= IDLE;
        end else begin
            node_q <= node_d;
            cnt_q <= cnt_d;
            cur_q <= cur_d;
            state_q <= state_d;
        end
    end
    assign o_top = node_q[0];
    assign o_count = cnt_q;
    assign o_full = cnt_q == NMAX;
    assign o_empty = cnt_q == '0;
    assign o_busy = state_q != IDLE;
    assign o_top_valid = (cnt_q != '0) && (state_q == IDLE);
endmodule

// File: tb/tb_register_tree_pq.sv
// tb_register_tree_pq: vector table, corner sequences and random ops
// against a multiset model of the priority queue.
module tb_register_tree_pq;
    localparam int DW = 32;
    localparam int TD = 3;
    localparam int N = 7;

    logic clk = 0;
    logic rst_n = 0;
    logic i_enq = 0;
    logic i_deq = 0;
    logic [DW-1:0] i_enq_data = '0;
    logic [DW-1:0] o_top;
    logic o_top_valid, o_busy, o_full, o_empty;
    logic [2:0] o_count;

    int total = 0;
    int bad = 0;
    int busy_cycles = 0;
    logic [DW-1:0] model [$];

    typedef struct {
        logic e;
        logic d;
        logic [DW-1:0] x;
        logic [DW-1:0] top;
        int cnt;
    } vec_t;
    vec_t vq [$];

    register_tree_pq #(.DATA_WIDTH(DW), .TREE_DEPTH(TD)) dut (
        .clk(clk), .rst_n(rst_n), .i_enq(i_enq), .i_enq_data(i_enq_data),
        .i_deq(i_deq), .o_top(o_top), .o_top_valid(o_top_valid),
        .o_busy(o_busy), .o_full(o_full), .o_empty(o_empty), .o_count(o_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [DW-1:0] model_max();
        logic [DW-1:0] m = '0;
        foreach (model[k]) if (model[k] > m) m = model[k];
        return m;
    endfunction

    function automatic void model_remove_max();
        int idx = 0;
        foreach (model[k]) if (model[k] > model[idx]) idx = k;
        model.delete(idx);
    endfunction

    function automatic void model_op(input logic e, input logic d, input logic [DW-1:0] x);
        int n = model.size();
        if (e && d && n > 0) begin
            model_remove_max();
            model.push_back(x);
        end else if (e && n < N) begin
            model.push_back(x);
        end else if (d && !e && n > 0) begin
            model_remove_max();
        end
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [DW-1:0] top, input int cnt);
        chk({nm, ".top"}, o_top, top);
        chk({nm, ".count"}, DW'(o_count), DW'(cnt));
        chk({nm, ".full"}, DW'(o_full), DW'(cnt == N));
        chk({nm, ".empty"}, DW'(o_empty), DW'(cnt == 0));
        chk({nm, ".valid"}, DW'(o_top_valid), DW'(cnt > 0));
        chk({nm, ".busy"}, DW'(o_busy), '0);
        chk({nm, ".busy_bound"}, DW'(busy_cycles <= TD), 1);
    endtask

    task automatic op(input logic e, input logic d, input logic [DW-1:0] x);
        i_enq = e;
        i_deq = d;
        i_enq_data = x;
        @(posedge clk);
        #1;
        i_enq = 0;
        i_deq = 0;
        model_op(e, d, x);
        busy_cycles = 0;
        while (o_busy && busy_cycles < 20) begin
            @(posedge clk);
            #1;
            busy_cycles++;
        end
    endtask

    task automatic do_reset();
        i_enq = 0;
        i_deq = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        model.delete();
        busy_cycles = 0;
    endtask

    initial begin
        vq.push_back(vec_t'{1'b1, 1'b0, 32'h10, 32'h10, 1});
        vq.push_back(vec_t'{1'b1, 1'b0, 32'h20, 32'h20, 2});
        vq.push_back(vec_t'{1'b1, 1'b0, 32'h30, 32'h30, 3});
        vq.push_back(vec_t'{1'b0, 1'b1, 32'h0, 32'h20, 2});
        vq.push_back(vec_t'{1'b0, 1'b1, 32'h0, 32'h10, 1});
        vq.push_back(vec_t'{1'b0, 1'b1, 32'h0, 32'h0, 0});
        for (int k = 1; k <= 7; k++) vq.push_back(vec_t'{1'b1, 1'b0, DW'(k), DW'(k), k});
        vq.push_back(vec_t'{1'b1, 1'b0, 32'h99, 32'h7, 7});
        for (int k = 6; k >= 0; k--) vq.push_back(vec_t'{1'b0, 1'b1, 32'h0, DW'(k), k});

        do_reset();
        chk_all("reset", '0, 0);

        foreach (vq[k]) begin
            op(vq[k].e, vq[k].d, vq[k].x);
            chk_all($sformatf("vec%0d", k), vq[k].top, vq[k].cnt);
        end

        // Replace-top on {0x40,0x20,0x30}
        do_reset();
        op(1, 0, 32'h40);
        op(1, 0, 32'h20);
        op(1, 0, 32'h30);
        op(1, 1, 32'h05);
        chk_all("replace", 32'h30, 3);
        op(0, 1, '0);
        chk_all("replace_d1", 32'h20, 2);
        op(0, 1, '0);
        chk_all("replace_d2", 32'h05, 1);

        // Equal keys: dequeue sifts with no swap, one busy cycle
        do_reset();
        repeat (3) op(1, 0, 32'h10);
        op(0, 1, '0);
        chk_all("equal", 32'h10, 2);
        chk("equal.busy_cycles", DW'(busy_cycles), 1);

        // Requests held while busy are ignored
        do_reset();
        op(1, 0, 32'h1);
        op(1, 0, 32'h2);
        op(1, 0, 32'h3);
        i_enq = 1;
        i_enq_data = 32'd100;
        @(posedge clk);
        #1;
        model_op(1, 0, 32'd100);
        i_deq = 1;
        i_enq_data = 32'hFFFF_FFFF;
        busy_cycles = 0;
        while (o_busy && busy_cycles < 20) begin
            @(posedge clk);
            #1;
            busy_cycles++;
        end
        i_enq = 0;
        i_deq = 0;
        chk_all("busy_ignore", 32'd100, 4);

        // Dequeue while empty
        do_reset();
        op(0, 1, '0);
        chk_all("deq_empty", '0, 0);

        // Reset pulse mid SIFT_UP
        do_reset();
        for (int k = 1; k <= 4; k++) op(1, 0, DW'(k));
        i_enq = 1;
        i_enq_data = 32'd100;
        @(posedge clk);
        #1;
        i_enq = 0;
        chk("midreset.sifting", DW'(o_busy), 1);
        rst_n = 0;
        #1;
        busy_cycles = 0;
        chk_all("midreset.async", '0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        model.delete();
        chk_all("midreset.release", '0, 0);
        op(1, 0, 32'h5);
        chk_all("midreset.first", 32'h5, 1);

        // Random ops against the multiset model
        do_reset();
        repeat (300) begin
            int r;
            logic e, d;
            logic [DW-1:0] x;
            r = $urandom_range(0, 9);
            e = (r < 5) || (r >= 8);
            d = (r >= 5);
            x = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 15));
            op(e, d, x);
            chk_all("rnd", model_max(), model.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/register_tree_pq.md
REGISTER_TREE_PQ -- requirements
Module: register_tree_pq

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, width of each stored key.
REQ-002 The block SHALL have parameter TREE_DEPTH, default 3, number of tree levels; capacity N = 2^TREE_DEPTH - 1 (7 at default).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have the following data and control ports.
- i_enq  input  1  enqueue request.
- i_enq_data  input  DATA_WIDTH  key to insert.
- i_deq  input  1  dequeue request; removes the maximum key.
- o_top  output  DATA_WIDTH  current maximum, node[0].
- o_top_valid  output  1  high when count > 0 and state is IDLE.
- o_busy  output  1  high when state is not IDLE.
- o_full  output  1  high when count == N.
- o_empty  output  1  high when count == 0.
- o_count  output  $clog2(N+1)  number of stored keys.

Function
REQ-005 Storage SHALL be N registers node[0..N-1] in level order: parent(i) = (i-1)/2, children 2i+1 and 2i+2. Valid nodes are indices < count.
REQ-006 Ordering SHALL be a max-heap: every valid parent SHALL be >= each valid child, using an unsigned compare.
REQ-007 The FSM SHALL have exactly three states: IDLE, SIFT_UP and SIFT_DOWN. It SHALL also hold a cursor register cur.
REQ-008 Requests SHALL be sampled only in IDLE. i_enq and i_deq SHALL be ignored while o_busy = 1, with no state change.
REQ-009 Enqueue only (IDLE, i_enq=1, i_deq=0, not full): node[count] <= i_enq_data, cur <= count, count++, next state SIFT_UP.
REQ-010 Enqueue only while full SHALL be dropped; storage, count and state stay unchanged.
REQ-011 Dequeue only (IDLE, i_deq=1, i_enq=0, count > 1): node[0] <= node[count-1], node[count-1] <= 0, count--, cur <= 0, next state SIFT_DOWN.
REQ-012 Dequeue only with count == 1: node[0] <= 0, count <= 0, state stays IDLE.
REQ-013 Dequeue only while empty SHALL be ignored.
REQ-014 Simultaneous i_enq and i_deq, count > 0: replace-top. node[0] <= i_enq_data, count unchanged, cur <= 0, next state SIFT_DOWN. This SHALL be permitted while full.
REQ-015 Simultaneous i_enq and i_deq, empty: SHALL behave as enqueue only.
REQ-016 SIFT_UP, one compare per cycle:
- If cur == 0 or node[cur] <= node[parent(cur)]: go to IDLE.
- Else: swap node[cur] with node[parent], cur <= parent, stay in SIFT_UP.
REQ-017 SIFT_DOWN, one compare per cycle:
- Consider only valid children.
- If there are none: go to IDLE.
- Else select the larger child; the left child wins a tie.
- If selected child > node[cur]: swap, cur <= child, stay in SIFT_DOWN.
- Else (equal keys never swap): go to IDLE.
REQ-018 o_busy SHALL be at most TREE_DEPTH consecutive cycles per accepted operation. The operation SHALL be accepted at edge T, and o_busy SHALL rise in the cycle after T.
REQ-019 o_top, o_full, o_empty and o_count SHALL be driven directly from registers; all outputs are registered or decoded from registered state.
REQ-020 o_top SHALL be meaningful only when o_top_valid = 1. Invalid nodes SHALL hold 0.

Reset
REQ-021 On rst_n low, asynchronously and regardless of state:
- all node[] = 0, count = 0, cur = 0, state = IDLE.
- o_top = 0, o_top_valid = 0, o_busy = 0, o_full = 0, o_empty = 1, o_count = 0.
REQ-022 Reset asserted mid-SIFT SHALL abandon the operation with no residual swap after release. The first request SHALL be accepted on the first rising edge with rst_n high.

Verification (defaults DATA_WIDTH=32, TREE_DEPTH=3; each enqueue waits for o_busy=0)
REQ-023 Enqueue 0x10, 0x20, 0x30 -> o_top=0x30, o_count=3, and each busy window is <= 3 cycles.
REQ-024 Enqueue 1..7 -> o_full=1, o_top=7. A further enqueue of 0x99 -> dropped, o_top=7, o_count=7.
REQ-025 From the full heap, 7 dequeues reading o_top before each -> sequence 7,6,5,4,3,2,1, then o_empty=1, o_top=0.
REQ-026 Heap {0x40,0x20,0x30}, simultaneous i_enq=0x05 and i_deq -> o_top=0x30, o_count=3, heap property holds.
REQ-027 Heap with 0x10 at all 3 nodes, one dequeue -> no swaps, o_busy for exactly 1 cycle, o_top=0x10, o_count=2.
REQ-028 Stimuli while o_busy=1 and i_deq while empty -> ignored. Reset pulse during SIFT_UP -> all outputs at reset values on the next sample.
